// File: rtl/mem_arbiter_2p.sv
// Two-port arbiter/sequencer sharing one single-port 256x8 memory.
// Each granted request runs IDLE -> ACCESS -> RESP, three cycles total.
module mem_arbiter_2p #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int RR     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_d_i,
    input  logic [DATA_W-1:0] mem_d_o,
    output logic              busy,
    output logic              gnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_d_i_q, mem_d_i_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              busy_q, busy_d;
    logic              gnt_q, gnt_d;
    logic              last_q, last_d;
    logic              pick;

    // Next-state logic: arbitration in IDLE, memory access and response later.
    always_comb begin
        state_d    = state_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_d_i_d  = mem_d_i_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        pick       = 1'b0;

        if (req0 && req1) begin
            pick = (RR != 0) ? ~last_q : 1'b0;
        end else begin
            pick = req1;
        end

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    mem_we_d   = pick ? we1    : we0;
                    mem_addr_d = pick ? addr1  : addr0;
                    mem_d_i_d  = pick ? wdata1 : wdata0;
                    gnt_d      = pick;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                // The write, if any, commits at this edge; reads sample mem_d_o now.
                if (!mem_we_q) begin
                    if (gnt_q) begin
                        rdata1_d = mem_d_o;
                    end else begin
                        rdata0_d = mem_d_o;
                    end
                end
                mem_we_d = 1'b0;
                ack0_d   = ~gnt_q;
                ack1_d   = gnt_q;
                last_d   = gnt_q;
                state_d  = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_d_i_q  <= '0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            busy_q     <= 1'b0;
            gnt_q      <= 1'b0;
            last_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_d_i_q  <= mem_d_i_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            busy_q     <= busy_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
        end
    end

    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_d_i  = mem_d_i_q;
    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign busy     = busy_q;
    assign gnt      = gnt_q;

endmodule

// File: tb/tb_mem_arbiter_2p.sv
// Bench for mem_arbiter_2p: a round-robin instance (A) and a fixed-priority
// instance (B) share stimulus, each with its own behavioural 256x8 memory.
module tb_mem_arbiter_2p;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, we0, req1, we1;
    logic [7:0] addr0, wdata0, addr1, wdata1;

    logic       ack0A, ack1A, memWeA, busyA, gntA;
    logic [7:0] rdata0A, rdata1A, memAddrA, memDiA, memDoA;
    logic       ack0B, ack1B, memWeB, busyB, gntB;
    logic [7:0] rdata0B, rdata1B, memAddrB, memDiB, memDoB;

    logic [7:0] memA [0:255];
    logic [7:0] memB [0:255];

    typedef struct {
        int         port;
        bit         isRead;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_arbiter_2p #(.ADDR_W(8), .DATA_W(8), .RR(1)) dutA (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0A), .rdata0(rdata0A),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1A), .rdata1(rdata1A),
        .mem_we(memWeA), .mem_addr(memAddrA), .mem_d_i(memDiA), .mem_d_o(memDoA),
        .busy(busyA), .gnt(gntA)
    );

    mem_arbiter_2p #(.ADDR_W(8), .DATA_W(8), .RR(0)) dutB (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0B), .rdata0(rdata0B),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1B), .rdata1(rdata1B),
        .mem_we(memWeB), .mem_addr(memAddrB), .mem_d_i(memDiB), .mem_d_o(memDoB),
        .busy(busyB), .gnt(gntB)
    );

    // Single-port memories: combinational read, write on the rising edge.
    assign memDoA = memA[memAddrA];
    assign memDoB = memB[memAddrB];
    always @(posedge clk) begin
        if (memWeA === 1'b1) memA[memAddrA] <= memDiA;
        if (memWeB === 1'b1) memB[memAddrB] <= memDiB;
    end

    // Drives one request on instance A and observes it until ack (bounded).
    task automatic runTxn(input bit port, input bit we, input logic [7:0] addr,
                          input logic [7:0] wdata, output int ackPort, output logic [7:0] rd,
                          output int lat, output int weCycles, output logic [7:0] weAddr,
                          output logic [7:0] weData);
        ackPort = -1; rd = 8'h00; lat = 0; weCycles = 0; weAddr = 8'h00; weData = 8'h00;
        if (port) begin
            req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
        end else begin
            req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
        end
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (memWeA === 1'b1) begin
                weCycles++;
                weAddr = memAddrA;
                weData = memDiA;
            end
            if (ack0A === 1'b1 || ack1A === 1'b1) begin
                ackPort = (ack1A === 1'b1) ? 1 : 0;
                rd      = (ack1A === 1'b1) ? rdata1A : rdata0A;
                lat     = i;
                break;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic waitIdle(input int n, output int acks, output int wes, output int busies);
        acks = 0; wes = 0; busies = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (ack0A !== 1'b0 || ack1A !== 1'b0) acks++;
            if (memWeA !== 1'b0) wes++;
            if (busyA !== 1'b0) busies++;
        end
    endtask

    task automatic doReset(input int n);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int got;
        rst = 1'b1;
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h00; wdata0 = 8'h11;
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h00; wdata1 = 8'h22;
        repeat (2) @(negedge clk);
        checks++;
        if ({ack0A, ack1A, memWeA, busyA, gntA} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: ack0,ack1,we,busy,gnt=%b required 00000",
                     {ack0A, ack1A, memWeA, busyA, gntA});
        end
        checks++;
        if ({rdata0A, rdata1A, memAddrA, memDiA} !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_data: rdata0=%h rdata1=%h addr=%h d_i=%h required all 00",
                     rdata0A, rdata1A, memAddrA, memDiA);
        end
        rst = 1'b0;
        got = -1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack0A === 1'b1 || ack1A === 1'b1) begin
                got = (ack1A === 1'b1) ? 1 : 0;
                break;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        checks++;
        if (got !== 0) begin
            errors++;
            $display("[TB] FAIL reset_first_grant: ack port %0d required 0", got);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write_read();
        int ap, lat, wc, acks, wes, bs;
        logic [7:0] rd, wa, wd;
        exp_t e;
        sb.push_back('{1, 1'b0, 8'h00});
        runTxn(1'b1, 1'b1, 8'h10, 8'h3C, ap, rd, lat, wc, wa, wd);
        e = sb.pop_front();
        checks++;
        if (ap !== e.port || lat !== 2) begin
            errors++;
            $display("[TB] FAIL wr_ack: port %0d latency %0d required port %0d latency 2", ap, lat, e.port);
        end
        checks++;
        if (wc !== 1 || wa !== 8'h10 || wd !== 8'h3C) begin
            errors++;
            $display("[TB] FAIL wr_mem: we cycles %0d addr %h data %h required 1 10 3c", wc, wa, wd);
        end
        waitIdle(3, acks, wes, bs);
        checks++;
        if (acks !== 0 || wes !== 0) begin
            errors++;
            $display("[TB] FAIL wr_single_pulse: extra acks %0d extra we %0d required 0 0", acks, wes);
        end
        sb.push_back('{0, 1'b1, 8'h3C});
        runTxn(1'b0, 1'b0, 8'h10, 8'h00, ap, rd, lat, wc, wa, wd);
        e = sb.pop_front();
        checks++;
        if (ap !== e.port || rd !== e.data || wc !== 0) begin
            errors++;
            $display("[TB] FAIL rd_data: port %0d rdata %h we cycles %0d required %0d %h 0",
                     ap, rd, wc, e.port, e.data);
        end
        waitIdle(3, acks, wes, bs);
        checks++;
        if (rdata0A !== 8'h3C || bs !== 0) begin
            errors++;
            $display("[TB] FAIL rd_hold: rdata0 %h busy cycles %0d required 3c 0", rdata0A, bs);
        end
    endtask

    task automatic test_arbitration();
        int ap, lat, wc, popped, b0, b1, gotB;
        logic [7:0] rd, wa, wd;
        exp_t e;
        doReset(2);
        runTxn(1'b1, 1'b1, 8'h02, 8'hFF, ap, rd, lat, wc, wa, wd);
        @(negedge clk);
        for (int k = 0; k < 4; k++) sb.push_back('{k % 2, 1'b1, 8'hFF});
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h02;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h02;
        popped = 0; b0 = 0; b1 = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (ack0B === 1'b1) b0++;
            if (ack1B === 1'b1) b1++;
            if (ack0A === 1'b1 && ack1A === 1'b1) begin
                checks++; errors++;
                $display("[TB] FAIL rr_dual_ack: both acks high at cycle %0d required one", i);
            end else if (ack0A === 1'b1 || ack1A === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL rr_extra_ack: ack at cycle %0d required none", i);
                end else begin
                    e = sb.pop_front();
                    ap = (ack1A === 1'b1) ? 1 : 0;
                    rd = (ack1A === 1'b1) ? rdata1A : rdata0A;
                    if (ap !== e.port || rd !== e.data || i !== 2 + 3 * popped) begin
                        errors++;
                        $display("[TB] FAIL rr_order: port %0d rdata %h cycle %0d required %0d %h %0d",
                                 ap, rd, i, e.port, e.data, 2 + 3 * popped);
                    end
                    popped++;
                end
            end
        end
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("[TB] FAIL rr_missing: %0d acks outstanding required 0", sb.size());
            sb.delete();
        end
        checks++;
        if (b0 !== 4 || b1 !== 0 || rdata0B !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL fixed_prio: ack0 %0d ack1 %0d rdata0 %h required 4 0 ff", b0, b1, rdata0B);
        end
        req0 = 1'b0;
        gotB = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack1B === 1'b1) begin
                gotB = 1;
                break;
            end
        end
        req1 = 1'b0;
        checks++;
        if (gotB !== 1 || rdata1B !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL fixed_prio_port1: ack1 seen %0d rdata1 %h required 1 ff", gotB, rdata1B);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int ap, lat, wc, acks, wes, bs;
        logic [7:0] rd, wa, wd;
        logic weSeen;
        runTxn(1'b0, 1'b1, 8'h01, 8'h3C, ap, rd, lat, wc, wa, wd);
        runTxn(1'b0, 1'b0, 8'h01, 8'h00, ap, rd, lat, wc, wa, wd);
        checks++;
        if (rd !== 8'h3C) begin
            errors++;
            $display("[TB] FAIL mid_preread: rdata0 %h required 3c", rd);
        end
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h01; wdata1 = 8'hAA;
        @(negedge clk);
        weSeen = memWeA;
        rst = 1'b1;
        req1 = 1'b0;
        @(negedge clk);
        checks++;
        if (weSeen !== 1'b1 || ack1A !== 1'b0 || rdata0A !== 8'h00 || busyA !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset: we_in_access %b ack1 %b rdata0 %h busy %b required 1 0 00 0",
                     weSeen, ack1A, rdata0A, busyA);
        end
        rst = 1'b0;
        waitIdle(3, acks, wes, bs);
        checks++;
        if (acks !== 0 || wes !== 0) begin
            errors++;
            $display("[TB] FAIL mid_no_ack: acks %0d we %0d required 0 0", acks, wes);
        end
        runTxn(1'b0, 1'b0, 8'h01, 8'h00, ap, rd, lat, wc, wa, wd);
        checks++;
        if (ap !== 0 || (rd !== 8'h3C && rd !== 8'hAA)) begin
            errors++;
            $display("[TB] FAIL mid_readback: port %0d rdata %h required 0 and 3c or aa", ap, rd);
        end
    endtask

    task automatic test_dropped_req();
        int ap, lat, wc, acks, wes, bs;
        logic [7:0] rd, wa, wd;
        @(negedge clk);
        runTxn(1'b0, 1'b0, 8'h10, 8'h00, ap, rd, lat, wc, wa, wd);
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h05; wdata1 = 8'h77;
        @(negedge clk);
        req1 = 1'b0;
        waitIdle(5, acks, wes, bs);
        checks++;
        if (ap !== 0 || acks !== 0 || wes !== 0 || bs !== 0) begin
            errors++;
            $display("[TB] FAIL dropped_req: port %0d acks %0d we %0d busy %0d required 0 0 0 0",
                     ap, acks, wes, bs);
        end
    endtask

    initial begin
        rst = 1'b1;
        req0 = 1'b0; we0 = 1'b0; addr0 = 8'h00; wdata0 = 8'h00;
        req1 = 1'b0; we1 = 1'b0; addr1 = 8'h00; wdata1 = 8'h00;
        test_reset();
        test_write_read();
        test_arbitration();
        test_reset_mid();
        test_dropped_req();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
